// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of a register file: buffers pending writes, drains them in
// FIFO order and forwards the youngest pending value to the two read ports.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       WrClk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_Rw,
    input  logic [DW-1:0]              in_busW,
    input  logic                       drain_en,
    output logic [AW-1:0]              Rw,
    output logic [DW-1:0]              busW,
    output logic                       RegWr,
    input  logic [AW-1:0]              Ra,
    input  logic [AW-1:0]              Rb,
    input  logic [DW-1:0]              busA,
    input  logic [DW-1:0]              busB,
    output logic [DW-1:0]              fwdA,
    output logic [DW-1:0]              fwdB,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [LW-1:0] level_reg, level_next;

    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (level_reg != '0);
    assign in_ready  = (level_reg < LW'(DEPTH));
    assign RegWr     = not_empty & drain_en;
    assign Rw        = not_empty ? addr_mem[head_reg] : '0;
    assign busW      = not_empty ? data_mem[head_reg] : '0;
    assign level     = level_reg;

    // Writes to register 0 are accepted but never stored.
    assign push = in_valid & in_ready & (in_Rw != '0);
    assign pop  = RegWr;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        level_next = level_reg;
        if (push) begin
            tail_next = tail_reg + 1'b1;
        end
        if (pop) begin
            head_next = head_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge WrClk) begin
        if (Rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            level_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            level_reg <= level_next;
        end
    end

    always_ff @(posedge WrClk) begin
        if (push && !Rst) begin
            addr_mem[tail_reg] <= in_Rw;
            data_mem[tail_reg] <= in_busW;
        end
    end

    // Entries are examined by age offset from the head; higher offset = younger.
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;
    logic [DW-1:0]    off_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_off
            logic [PW-1:0] idx;
            logic          occ;
            assign idx          = head_reg + PW'(gi);
            assign occ          = (LW'(gi) < level_reg);
            assign match_a[gi]  = occ && (addr_mem[idx] == Ra);
            assign match_b[gi]  = occ && (addr_mem[idx] == Rb);
            assign off_data[gi] = data_mem[idx];
        end
    endgenerate

    always_comb begin
        fwdA = busA;
        fwdB = busB;
        for (int k = 0; k < DEPTH; k++) begin
            if (match_a[k]) begin
                fwdA = off_data[k];
            end
            if (match_b[k]) begin
                fwdB = off_data[k];
            end
        end
        if (Ra == '0) begin
            fwdA = '0;
        end
        if (Rb == '0) begin
            fwdB = '0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: push/drain ordering, forwarding, full handling,
// register-0 discard, wrap-around and mid-operation reset.
module tb_regfile_wb_queue;
    logic        WrClk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_Rw;
    logic [31:0] in_busW;
    logic        drain_en;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic        RegWr;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] fwdA;
    logic [31:0] fwdB;
    logic [2:0]  level;

    int n_compared   = 0;
    int n_mismatched = 0;

    regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .WrClk    (WrClk),
        .Rst      (Rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_Rw    (in_Rw),
        .in_busW  (in_busW),
        .drain_en (drain_en),
        .Rw       (Rw),
        .busW     (busW),
        .RegWr    (RegWr),
        .Ra       (Ra),
        .Rb       (Rb),
        .busA     (busA),
        .busB     (busB),
        .fwdA     (fwdA),
        .fwdB     (fwdB),
        .level    (level)
    );

    always #5 WrClk = ~WrClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %s: %08h", tag, obs);
        end
    endtask

    // Advance past the next rising edge; inputs change #1 afterwards.
    task automatic step();
        @(posedge WrClk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        Rst = 1'b1; in_valid = 1'b0; in_Rw = '0; in_busW = '0; drain_en = 1'b0;
        Ra = '0; Rb = '0; busA = '0; busB = '0;
        step();
        step();
        Rst = 1'b0;
        Ra = 5'd3; busA = 32'h0000_1234;
        settle();
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_regwr", 32'(RegWr), 32'd0);
        check("rst_rw", 32'(Rw), 32'd0);
        check("rst_busw", busW, 32'd0);
        check("rst_fwda_pass", fwdA, 32'h0000_1234);
        Ra = 5'd0;
        settle();
        check("rst_fwda_r0", fwdA, 32'd0);

        // Single push with forwarding, not forwarded while only presented.
        in_valid = 1'b1; in_Rw = 5'd1; in_busW = 32'hA5A5_A5A5; Ra = 5'd1; busA = 32'd0;
        settle();
        check("t36_no_fwd_presented", fwdA, 32'd0);
        step();
        in_valid = 1'b0;
        settle();
        check("t36_level", 32'(level), 32'd1);
        check("t36_regwr", 32'(RegWr), 32'd0);
        check("t36_fwda", fwdA, 32'hA5A5_A5A5);
        check("t36_head_rw", 32'(Rw), 32'd1);
        check("t36_head_busw", busW, 32'hA5A5_A5A5);
        drain_en = 1'b1;
        settle();
        check("t36_drain_regwr", 32'(RegWr), 32'd1);
        step();
        drain_en = 1'b0;
        settle();
        check("t36_after_level", 32'(level), 32'd0);

        // Two writes to the same register: youngest forwarded, oldest drained first.
        in_valid = 1'b1; in_Rw = 5'd2; in_busW = 32'h1111_1111;
        step();
        in_busW = 32'h6B6B_6B6B;
        step();
        in_valid = 1'b0; Rb = 5'd2; busB = 32'h0000_DEAD;
        settle();
        check("t37_level", 32'(level), 32'd2);
        check("t37_fwdb_young", fwdB, 32'h6B6B_6B6B);
        drain_en = 1'b1;
        settle();
        check("t37_pop1_regwr", 32'(RegWr), 32'd1);
        check("t37_pop1_rw", 32'(Rw), 32'd2);
        check("t37_pop1_busw", busW, 32'h1111_1111);
        step();
        check("t37_pop2_regwr", 32'(RegWr), 32'd1);
        check("t37_pop2_busw", busW, 32'h6B6B_6B6B);
        check("t37_pop2_fwdb", fwdB, 32'h6B6B_6B6B);
        step();
        check("t37_empty_level", 32'(level), 32'd0);
        check("t37_empty_regwr", 32'(RegWr), 32'd0);
        check("t37_empty_fwdb", fwdB, 32'h0000_DEAD);
        drain_en = 1'b0;

        // Write to register 0 is swallowed.
        in_valid = 1'b1; in_Rw = 5'd0; in_busW = 32'hFFFF_FFFF;
        settle();
        check("t38_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; drain_en = 1'b1; Ra = 5'd0; busA = 32'hFFFF_FFFF;
        settle();
        check("t38_level", 32'(level), 32'd0);
        check("t38_regwr", 32'(RegWr), 32'd0);
        check("t38_fwda_r0", fwdA, 32'd0);
        drain_en = 1'b0;

        // Fill to full (storage wraps: head sits at slot 3).
        for (int a = 3; a <= 6; a++) begin
            in_valid = 1'b1; in_Rw = 5'(a); in_busW = 32'h100 + 32'(a);
            step();
        end
        in_valid = 1'b0;
        Ra = 5'd6; busA = 32'd0; Rb = 5'd3; busB = 32'd0;
        settle();
        check("t39_full_level", 32'(level), 32'd4);
        check("t39_full_ready", 32'(in_ready), 32'd0);
        check("t39_fwda_wrap", fwdA, 32'h0000_0106);
        check("t39_fwdb_head", fwdB, 32'h0000_0103);
        in_valid = 1'b1; in_Rw = 5'd7; in_busW = 32'h0000_0107; drain_en = 1'b1;
        settle();
        check("t39_full_regwr", 32'(RegWr), 32'd1);
        check("t39_full_rw", 32'(Rw), 32'd3);
        check("t39_full_ready_drain", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0; drain_en = 1'b0; Ra = 5'd7; busA = 32'h0000_0077;
        settle();
        check("t39_after_level", 32'(level), 32'd3);
        check("t39_after_ready", 32'(in_ready), 32'd1);
        check("t39_after_rw", 32'(Rw), 32'd4);
        check("t39_no_push_fwda", fwdA, 32'h0000_0077);
        drain_en = 1'b1;
        for (int a = 4; a <= 6; a++) begin
            settle();
            check($sformatf("t39_drain_rw%0d", a), 32'(Rw), 32'(a));
            step();
        end
        drain_en = 1'b0;
        settle();
        check("t39_drained_level", 32'(level), 32'd0);

        // Streaming push and drain through the wrap point.
        in_valid = 1'b1; in_Rw = 5'd1; in_busW = 32'd1; drain_en = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            if (k < 10) begin
                in_valid = 1'b1; in_Rw = 5'(k + 1); in_busW = 32'(k + 1);
            end else begin
                in_valid = 1'b0;
            end
            settle();
            check($sformatf("t40_regwr_%0d", k), 32'(RegWr), 32'd1);
            check($sformatf("t40_rw_%0d", k), 32'(Rw), 32'(k));
            check($sformatf("t40_level_%0d", k), 32'(level), 32'd1);
            step();
        end
        check("t40_end_level", 32'(level), 32'd0);
        drain_en = 1'b0;

        // Reset in mid-operation discards pending entries and the presented request.
        for (int a = 8; a <= 10; a++) begin
            in_valid = 1'b1; in_Rw = 5'(a); in_busW = 32'h900 + 32'(a);
            step();
        end
        in_valid = 1'b0; Ra = 5'd9; busA = 32'h0000_0055;
        settle();
        check("t41_level", 32'(level), 32'd3);
        check("t41_fwda_pending", fwdA, 32'h0000_0909);
        Rst = 1'b1; in_valid = 1'b1; in_Rw = 5'd11; in_busW = 32'h0000_0B0B;
        step();
        Rst = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
        settle();
        check("t41_rst_level", 32'(level), 32'd0);
        check("t41_rst_regwr", 32'(RegWr), 32'd0);
        check("t41_rst_rw", 32'(Rw), 32'd0);
        check("t41_rst_fwda", fwdA, 32'h0000_0055);
        step();
        check("t41_dropped_level", 32'(level), 32'd0);
        check("t41_dropped_regwr", 32'(RegWr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
